// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory access unit: access sizes, FSM states
// and the alignment rule used by the reject logic.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WRITE = 2'b01,
    ST_ACK   = 2'b10
  } state_t;

  // Halfwords need addr[0]=0, words need addr[1:0]=00; bytes are always aligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    return ((size == SZ_HALF) && lo[0]) || ((size == SZ_WORD) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lane_mux.sv
// Combinational lane logic: load extraction/extension and sub-word store merge.
// Lanes are little-endian (addr[1:0]=0 is bits [7:0]).
module mem_lane_mux
  import mem_pkg::*;
(
  input  logic [31:0] ld_word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] ld_data,
  input  logic [31:0] st_old,
  input  logic [31:0] st_wdata,
  output logic [31:0] st_merged
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Select the addressed lane(s) and extend to 32 bits.
  always_comb begin
    ld_byte = ld_word[7:0];
    case (addr_lo)
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      2'd3:    ld_byte = ld_word[31:24];
      default: ld_byte = ld_word[7:0];
    endcase
    ld_half = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
    case (size)
      SZ_BYTE: ld_data = {{24{is_signed & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data = {{16{is_signed & ld_half[15]}}, ld_half};
      default: ld_data = ld_word;
    endcase
  end

  // Each byte lane either keeps the old RAM byte or takes the matching store byte.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      logic       hit;
      logic [7:0] src;

      // Decide whether this lane is overwritten and which store byte feeds it.
      always_comb begin
        case (size)
          SZ_BYTE: begin
            hit = (addr_lo == LANE);
            src = st_wdata[7:0];
          end
          SZ_HALF: begin
            hit = (addr_lo[1] == LANE[1]);
            src = st_wdata[8*(gi%2) +: 8];
          end
          default: begin
            hit = 1'b1;
            src = st_wdata[8*gi +: 8];
          end
        endcase
      end

      assign st_merged[8*gi +: 8] = hit ? src : st_old[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access unit: turns byte/half/word load/store requests into
// cycles on a word-addressed RAM without byte enables. Sub-word stores use a
// read-modify-write through the WRITE state; bad requests complete with err.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int RAM_SIZE = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        ready,
  output logic        ack,
  output logic        err,
  output logic [31:0] rdata,
  output logic        MemRd,
  output logic        MemWr,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWrtData,
  input  logic [31:0] MemRdData
);

  localparam logic [31:0] RAM_WORDS = 32'(RAM_SIZE);

  state_t      state_reg, state_next;
  logic        err_reg;
  logic [31:0] rdata_reg;
  logic [31:0] merge_reg;
  logic [29:0] waddr_reg;

  logic        accept;
  logic        reject;
  logic        is_word_store;
  logic        is_sub_store;
  logic [31:0] ld_data;
  logic [31:0] st_merged;

  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata;

  assign ready  = (state_reg == ST_IDLE);
  assign ack    = (state_reg == ST_ACK);
  assign err    = ack & err_reg;
  assign rdata  = rdata_reg;
  assign accept = ready & req;

  // A request is rejected for illegal size, misalignment, or a word index past the RAM.
  assign reject = (req_size == SZ_ILLEGAL)
               || is_misaligned(req_size, req_addr[1:0])
               || ({2'b00, req_addr[31:2]} >= RAM_WORDS);

  assign is_word_store = req_we && (req_size == SZ_WORD);
  assign is_sub_store  = req_we && (req_size != SZ_WORD);

  mem_lane_mux u_lane_mux (
    .ld_word   (MemRdData),
    .addr_lo   (req_addr[1:0]),
    .size      (req_size),
    .is_signed (req_signed),
    .ld_data   (ld_data),
    .st_old    (MemRdData),
    .st_wdata  (req_wdata),
    .st_merged (st_merged)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Next state and RAM port drive; the port is quiet unless an access is live.
  always_comb begin
    state_next = state_reg;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = 32'd0;
    mem_wdata  = 32'd0;
    case (state_reg)
      ST_IDLE: begin
        if (req) begin
          if (reject) begin
            state_next = ST_ACK;
          end else begin
            mem_addr   = {req_addr[31:2], 2'b00};
            mem_rd     = !is_word_store;
            mem_wr     = is_word_store;
            mem_wdata  = is_word_store ? req_wdata : 32'd0;
            state_next = is_sub_store ? ST_WRITE : ST_ACK;
          end
        end
      end
      ST_WRITE: begin
        mem_wr     = 1'b1;
        mem_addr   = {waddr_reg, 2'b00};
        mem_wdata  = merge_reg;
        state_next = ST_ACK;
      end
      ST_ACK: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Reset kills the port at once, so an in-flight merge write never lands.
  assign MemRd      = mem_rd & ~reset;
  assign MemWr      = mem_wr & ~reset;
  assign MemAddr    = reset ? 32'd0 : mem_addr;
  assign MemWrtData = reset ? 32'd0 : mem_wdata;

  // Capture completion status, load result and the pending merge on acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_reg   <= 1'b0;
      rdata_reg <= 32'd0;
      merge_reg <= 32'd0;
      waddr_reg <= 30'd0;
    end else if (accept) begin
      err_reg <= reject;
      if (!reject && !req_we) rdata_reg <= ld_data;
      if (!reject && is_sub_store) begin
        merge_reg <= st_merged;
        waddr_reg <= req_addr[31:2];
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases from the test plan, then random
// requests checked against a byte-level memory model, then reset in WRITE.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        ready, ack, err, MemRd, MemWr;
  logic [31:0] rdata, MemAddr, MemWrtData, MemRdData;

  logic [31:0] ram [0:255];
  logic [31:0] mdl [0:255];
  logic [31:0] exp_rdata;
  int          checks = 0;
  int          errors = 0;
  int          txn = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.RAM_SIZE(256)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .ready      (ready),
    .ack        (ack),
    .err        (err),
    .rdata      (rdata),
    .MemRd      (MemRd),
    .MemWr      (MemWr),
    .MemAddr    (MemAddr),
    .MemWrtData (MemWrtData),
    .MemRdData  (MemRdData)
  );

  // Attached RAM: combinational read, synchronous write.
  assign MemRdData = ram[MemAddr[9:2]];
  always @(posedge clk) if (MemWr) ram[MemAddr[9:2]] <= MemWrtData;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One request: model the expected result, drive it, follow it to ack.
  task automatic xact(input logic we, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd_o, output logic err_o);
    logic        rej, sub, got;
    int          lo, widx, lat_exp, lat, wr_seen;
    logic [31:0] w, v, mask;
    rej  = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || (a[31:2] >= 30'd256);
    sub  = we && (sz != 2'd2);
    lo   = int'(a[1:0]);
    widx = int'(a[9:2]);
    lat_exp = (!rej && sub) ? 2 : 1;
    if (!rej && !we) begin
      w = mdl[widx];
      if (sz == 2'd0) begin
        v = (w >> (8*lo)) & 32'hFF;
        if (sg && v[7]) v = v | 32'hFFFFFF00;
      end else if (sz == 2'd1) begin
        v = (w >> (8*lo)) & 32'hFFFF;
        if (sg && v[15]) v = v | 32'hFFFF0000;
      end else begin
        v = w;
      end
      exp_rdata = v;
    end
    if (!rej && we) begin
      mask = (sz == 2'd0) ? (32'hFF << (8*lo)) : (sz == 2'd1) ? (32'hFFFF << (8*lo)) : 32'hFFFFFFFF;
      mdl[widx] = (mdl[widx] & ~mask) | ((wd << (8*lo)) & mask);
    end

    @(posedge clk); #1;
    req = 1'b1; req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    @(negedge clk);
    check("ready_T", 32'(ready), 32'd1);
    check("memrd_T", 32'(MemRd), 32'(!rej && (!we || sz != 2'd2)));
    check("memwr_T", 32'(MemWr), 32'(!rej && we && sz == 2'd2));
    if (!rej) check("memaddr_T", MemAddr, {a[31:2], 2'b00});
    if (!rej && we && sz == 2'd2) check("memwdata_T", MemWrtData, wd);

    // While busy, throw junk at the request port; it must be ignored.
    @(posedge clk); #1;
    req = 1'(($urandom)); req_we = 1'($urandom); req_size = 2'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    got = 1'b0; lat = 0; wr_seen = 0;
    for (int c = 1; c <= 4 && !got; c++) begin
      @(negedge clk);
      if (MemWr) wr_seen++;
      if (ack) begin got = 1'b1; lat = c; end
    end
    req = 1'b0;
    check("ack_seen", 32'(got), 32'd1);
    if (got) begin
      check("latency", 32'(lat), 32'(lat_exp));
      check("err", 32'(err), 32'(rej));
      check("rdata", rdata, exp_rdata);
      check("ready_at_ack", 32'(ready), 32'd0);
      check("late_writes", 32'(wr_seen), 32'(!rej && sub));
    end
    if (a[31:2] < 30'd256) check("ram_word", ram[widx], mdl[widx]);
    rd_o  = rdata;
    err_o = err;
    txn++;
    $display("txn %0d we=%0d size=%0d signed=%0d addr=%h wdata=%h -> err=%0d rdata=%h latency=%0d",
             txn, we, sz, sg, a, wd, err, rdata, lat);
  endtask

  initial begin
    logic [31:0] rd, a;
    logic        e;
    int          r;

    reset = 1'b1; req = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0;
    for (int i = 0; i < 256; i++) begin
      ram[i] = $urandom;
      mdl[i] = ram[i];
    end
    ram[4] = 32'h8899AABB;
    mdl[4] = 32'h8899AABB;
    exp_rdata = 32'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_memrd", 32'(MemRd), 32'd0);
    check("rst_memwr", 32'(MemWr), 32'd0);
    check("rst_memaddr", MemAddr, 32'd0);
    reset = 1'b0;

    // Directed cases.
    xact(1'b0, 2'd0, 1'b1, 32'h11, 32'd0, rd, e);
    check("lb_0x11", rd, 32'hFFFFFFAA);
    xact(1'b0, 2'd1, 1'b0, 32'h12, 32'd0, rd, e);
    check("lhu_0x12", rd, 32'h00008899);
    xact(1'b0, 2'd1, 1'b1, 32'h12, 32'd0, rd, e);
    check("lh_0x12", rd, 32'hFFFF8899);
    xact(1'b1, 2'd0, 1'b0, 32'h13, 32'h0000005C, rd, e);
    check("sb_word4", ram[4], 32'h5C99AABB);
    xact(1'b1, 2'd2, 1'b0, 32'h20, 32'h12345678, rd, e);
    xact(1'b0, 2'd2, 1'b0, 32'h20, 32'd0, rd, e);
    check("lw_0x20", rd, 32'h12345678);
    xact(1'b1, 2'd1, 1'b0, 32'h21, 32'h0000CAFE, rd, e);
    check("sh_misaligned_err", 32'(e), 32'd1);
    xact(1'b1, 2'd2, 1'b0, 32'h400, 32'hDEADBEEF, rd, e);
    check("sw_range_err", 32'(e), 32'd1);
    xact(1'b0, 2'd3, 1'b0, 32'h30, 32'd0, rd, e);
    check("size11_err", 32'(e), 32'd1);
    xact(1'b1, 2'd0, 1'b0, 32'h3FF, 32'h000000A5, rd, e);
    check("sb_last_byte_ok", 32'(e), 32'd0);

    // Random requests, biased toward a few low words so stores and loads collide.
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = $urandom;
      else if (r == 1) a = {22'd0, 8'(0), 2'b00} + (32'($urandom_range(250, 263)) << 2) + 32'($urandom_range(0, 3));
      else             a = (32'($urandom_range(0, 15)) << 2) + 32'($urandom_range(0, 3));
      xact(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom, rd, e);
    end

    // Reset while the merged halfword is waiting in WRITE.
    @(posedge clk); #1;
    req = 1'b1; req_we = 1'b1; req_size = 2'd1; req_signed = 1'b0;
    req_addr = 32'h14; req_wdata = 32'h0000BEEF;
    @(negedge clk);
    check("rmw_read_T", 32'(MemRd), 32'd1);
    @(posedge clk); #1;
    req = 1'b0;
    #1;
    check("rmw_in_write", 32'(MemWr), 32'd1);
    reset = 1'b1;
    #1;
    check("rstw_memwr", 32'(MemWr), 32'd0);
    check("rstw_memrd", 32'(MemRd), 32'd0);
    check("rstw_memaddr", MemAddr, 32'd0);
    check("rstw_ready", 32'(ready), 32'd1);
    check("rstw_ack", 32'(ack), 32'd0);
    check("rstw_err", 32'(err), 32'd0);
    check("rstw_rdata", rdata, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("rstw_word5", ram[5], mdl[5]);
    reset = 1'b0;
    exp_rdata = 32'd0;
    repeat (3) @(negedge clk);
    check("idle_word5", ram[5], mdl[5]);
    xact(1'b0, 2'd1, 1'b1, 32'h14, 32'd0, rd, e);
    xact(1'b0, 2'd2, 1'b0, 32'h14, 32'd0, rd, e);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
